saturn_bus_mem: RTL

- Nibble-wide memory device on the Saturn bus, directly downstream of the CPU bus controller. It consumes the controller's strobe, command/data flag and data nibble, and drives the returned data nibble.
- Decodes bus commands, assembles 5-nibble addresses, and keeps its own PC and DP pointers.
- Serves PC/DP reads and writes from an internal nibble RAM, so simulation and FPGA builds have a real bus target.

---
 rtl/saturn_bus_mem.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/saturn_bus_mem.sv
// Saturn bus nibble memory target: command decode, 5-nibble address assembly, PC/DP pointers.
// Optional SATURN_BUS_MEM_CONFIG_EN enables CONFIGURE/UNCONFIGURE base mapping.
module saturn_bus_mem #(
`ifdef SIM
  parameter int unsigned ADDR_BITS = 20
`else
  parameter int unsigned ADDR_BITS = 10
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bus_strobe,
  input  logic       i_bus_cmd_data,
  input  logic [3:0] i_bus_data,
  output logic [3:0] o_bus_data,
  output logic       o_bus_ack,
  output logic       o_configured,
  output logic [3:0] o_mode
);
  localparam int unsigned PTR_BITS = 20;
  localparam int unsigned NIB_BITS = 4;
  localparam int unsigned CNT_BITS = 3;
  localparam int unsigned SHD_BITS = 16;
  localparam int unsigned DEPTH    = 1 << ADDR_BITS;

  localparam logic [NIB_BITS-1:0] CMD_PC_READ     = 4'h0;
  localparam logic [NIB_BITS-1:0] CMD_DP_READ     = 4'h1;
  localparam logic [NIB_BITS-1:0] CMD_PC_WRITE    = 4'h2;
  localparam logic [NIB_BITS-1:0] CMD_DP_WRITE    = 4'h3;
  localparam logic [NIB_BITS-1:0] CMD_LOAD_PC     = 4'h4;
  localparam logic [NIB_BITS-1:0] CMD_LOAD_DP     = 4'h5;
  localparam logic [NIB_BITS-1:0] CMD_CONFIGURE   = 4'h6;
  localparam logic [NIB_BITS-1:0] CMD_UNCONFIGURE = 4'h7;
  localparam logic [NIB_BITS-1:0] CMD_RESET       = 4'hF;

  typedef enum logic [1:0] {IDLE, ADDR, XFER} state_t;

  state_t                state, state_n;
  logic [NIB_BITS-1:0]   mode_n;
  logic [CNT_BITS-1:0]   addr_cnt, addr_cnt_n;
  logic [SHD_BITS-1:0]   shadow, shadow_n;
  logic [PTR_BITS-1:0]   pc_ptr, pc_ptr_n, dp_ptr, dp_ptr_n;
  logic [NIB_BITS-1:0]   bus_data_n;
  logic                  bus_ack_n;

  logic                  cmd_strobe, data_strobe;
  logic [PTR_BITS-1:0]   ptr, ptr_inc, addr_full;
  logic [ADDR_BITS-1:0]  mem_idx;
  logic                  mapped, mem_we;

  logic [NIB_BITS-1:0]   mem [DEPTH];

  assign cmd_strobe  = i_bus_strobe && !i_bus_cmd_data;
  assign data_strobe = i_bus_strobe && i_bus_cmd_data;
  // In XFER the mode is always 0..3: bit 0 picks DP, bit 1 selects write.
  assign ptr       = o_mode[0] ? dp_ptr : pc_ptr;
  assign ptr_inc   = ptr + PTR_BITS'(1);
  assign addr_full = {i_bus_data, shadow};

`ifdef SATURN_BUS_MEM_CONFIG_EN
  logic [PTR_BITS-1:0] base, base_n, offset;
  logic                configured_n;

  assign offset  = ptr - base;
  assign mapped  = o_configured && (ptr >= base) && ({1'b0, offset} < (PTR_BITS + 1)'(DEPTH));
  assign mem_idx = offset[ADDR_BITS-1:0];
`else
  assign mapped       = 1'b1;
  assign mem_idx      = ptr[ADDR_BITS-1:0];
  assign o_configured = 1'b1;
`endif

  // Next-state, pointer and response logic
  always_comb begin
    state_n    = state;
    mode_n     = o_mode;
    addr_cnt_n = addr_cnt;
    shadow_n   = shadow;
    pc_ptr_n   = pc_ptr;
    dp_ptr_n   = dp_ptr;
    bus_data_n = o_bus_data;
    bus_ack_n  = 1'b0;
    mem_we     = 1'b0;
`ifdef SATURN_BUS_MEM_CONFIG_EN
    base_n       = base;
    configured_n = o_configured;
`endif
    if (cmd_strobe) begin
      mode_n     = i_bus_data;
      addr_cnt_n = '0;
      case (i_bus_data)
        CMD_LOAD_PC, CMD_LOAD_DP, CMD_CONFIGURE, CMD_UNCONFIGURE: state_n = ADDR;
        CMD_PC_READ, CMD_DP_READ, CMD_PC_WRITE, CMD_DP_WRITE:     state_n = XFER;
        CMD_RESET: begin
          state_n = IDLE;
`ifdef SATURN_BUS_MEM_CONFIG_EN
          configured_n = 1'b0;
`endif
        end
        default: state_n = IDLE;
      endcase
    end else if (data_strobe) begin
      case (state)
        ADDR: begin
          if (addr_cnt == CNT_BITS'(4)) begin
            addr_cnt_n = '0;
            case (o_mode)
              CMD_LOAD_PC: begin
                pc_ptr_n = addr_full;
                mode_n   = CMD_PC_READ;
                state_n  = XFER;
              end
              CMD_LOAD_DP: begin
                dp_ptr_n = addr_full;
                mode_n   = CMD_DP_READ;
                state_n  = XFER;
              end
              CMD_CONFIGURE: begin
`ifdef SATURN_BUS_MEM_CONFIG_EN
                base_n       = addr_full;
                configured_n = 1'b1;
`endif
                state_n = IDLE;
              end
              CMD_UNCONFIGURE: begin
`ifdef SATURN_BUS_MEM_CONFIG_EN
                if (addr_full == base) configured_n = 1'b0;
`endif
                state_n = IDLE;
              end
              default: state_n = IDLE;
            endcase
          end else begin
            shadow_n[{addr_cnt[1:0], 2'b00} +: NIB_BITS] = i_bus_data;
            addr_cnt_n = addr_cnt + CNT_BITS'(1);
          end
        end
        XFER: begin
          // Pointer advances even when the access falls outside the mapped window.
          if (o_mode[0]) dp_ptr_n = ptr_inc;
          else           pc_ptr_n = ptr_inc;
          if (o_mode[1]) begin
            mem_we = mapped;
          end else if (mapped) begin
            bus_data_n = mem[mem_idx];
            bus_ack_n  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mode     <= CMD_RESET;
      addr_cnt   <= '0;
      shadow     <= '0;
      pc_ptr     <= '0;
      dp_ptr     <= '0;
      o_bus_data <= '0;
      o_bus_ack  <= 1'b0;
`ifdef SATURN_BUS_MEM_CONFIG_EN
      base         <= '0;
      o_configured <= 1'b0;
`endif
    end else begin
      o_mode     <= mode_n;
      addr_cnt   <= addr_cnt_n;
      shadow     <= shadow_n;
      pc_ptr     <= pc_ptr_n;
      dp_ptr     <= dp_ptr_n;
      o_bus_data <= bus_data_n;
      o_bus_ack  <= bus_ack_n;
`ifdef SATURN_BUS_MEM_CONFIG_EN
      base         <= base_n;
      o_configured <= configured_n;
`endif
    end
  end

  // Nibble RAM; reset leaves contents intact but blocks a same-cycle write
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_reset) mem[mem_idx] <= i_bus_data;
  end

endmodule
